// File: rtl/quaternion_mult_seq.sv
// Sequential Hamilton product q = a * b (or a * conj(b)) using MULTS time-shared multipliers.
// Optional build macro QMUL_SAT_EN: saturate to OUT_W and add the sat_flag output.
module quaternion_mult_seq #(
  parameter int W     = 16,
  parameter int OUT_W = 2*W+2,
  parameter int MULTS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    conj_b,
  input  logic signed [W-1:0]     a0,
  input  logic signed [W-1:0]     a1,
  input  logic signed [W-1:0]     a2,
  input  logic signed [W-1:0]     a3,
  input  logic signed [W-1:0]     b0,
  input  logic signed [W-1:0]     b1,
  input  logic signed [W-1:0]     b2,
  input  logic signed [W-1:0]     b3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] q0,
  output logic signed [OUT_W-1:0] q1,
  output logic signed [OUT_W-1:0] q2,
  output logic signed [OUT_W-1:0] q3
`ifdef QMUL_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int ACC_W = 2*W+2;
  localparam int OPW   = W+1;
  localparam logic [3:0] K_STEP = 4'(MULTS);
  localparam logic [3:0] K_LAST = 4'(16 - MULTS);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                   state_q;
  logic [3:0]               k_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic signed [OPW-1:0]    a_q [4];
  logic signed [OPW-1:0]    b_q [4];
  logic signed [ACC_W-1:0]  acc_q [4];
  logic signed [ACC_W-1:0]  acc_d [4];
  logic signed [OUT_W-1:0]  res_q [4];
  logic signed [OUT_W-1:0]  res_d [4];

  logic signed [W-1:0]      a_in [4];
  logic signed [W-1:0]      b_in [4];
  logic signed [OPW-1:0]    a_cap [4];
  logic signed [OPW-1:0]    b_cap [4];
  logic signed [ACC_W-1:0]  term [MULTS];
  logic signed [ACC_W-1:0]  step_sum;

  // Product p = 4*i + j: a index is always j; returns {negate, b index}.
  function automatic logic [2:0] term_sel(input logic [3:0] p);
    logic [2:0] s;
    case (p)
      4'd0:    s = 3'b000;
      4'd1:    s = 3'b101;
      4'd2:    s = 3'b110;
      4'd3:    s = 3'b111;
      4'd4:    s = 3'b001;
      4'd5:    s = 3'b000;
      4'd6:    s = 3'b011;
      4'd7:    s = 3'b110;
      4'd8:    s = 3'b010;
      4'd9:    s = 3'b111;
      4'd10:   s = 3'b000;
      4'd11:   s = 3'b001;
      4'd12:   s = 3'b011;
      4'd13:   s = 3'b010;
      4'd14:   s = 3'b101;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  assign a_in[0] = a0;
  assign a_in[1] = a1;
  assign a_in[2] = a2;
  assign a_in[3] = a3;
  assign b_in[0] = b0;
  assign b_in[1] = b1;
  assign b_in[2] = b2;
  assign b_in[3] = b3;

  // One extra bit so that negating the most negative b component cannot overflow.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign a_cap[gi] = {a_in[gi][W-1], a_in[gi]};
    if (gi == 0) begin : g_scalar
      assign b_cap[gi] = {b_in[gi][W-1], b_in[gi]};
    end else begin : g_vector
      assign b_cap[gi] = conj_b ? -{b_in[gi][W-1], b_in[gi]} : {b_in[gi][W-1], b_in[gi]};
    end
  end

  for (genvar gi = 0; gi < MULTS; gi++) begin : g_mult
    logic [3:0]              p;
    logic [2:0]              sel;
    logic signed [ACC_W-1:0] a_w;
    logic signed [ACC_W-1:0] b_w;
    logic signed [ACC_W-1:0] prod;
    assign p    = k_q + 4'(gi);
    assign sel  = term_sel(p);
    assign a_w  = {{(ACC_W-OPW){a_q[p[1:0]][OPW-1]}}, a_q[p[1:0]]};
    assign b_w  = {{(ACC_W-OPW){b_q[sel[1:0]][OPW-1]}}, b_q[sel[1:0]]};
    assign prod = a_w * b_w;
    assign term[gi] = sel[2] ? -prod : prod;
  end

  // k advances in multiples of MULTS, so every product of one step targets the same output.
  always_comb begin
    step_sum = '0;
    for (int m = 0; m < MULTS; m++) begin
      step_sum = step_sum + term[m];
    end
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
    end
    acc_d[k_q[3:2]] = acc_q[k_q[3:2]] + step_sum;
  end

`ifdef QMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic [3:0] clip;
  logic       sat_d;
  logic       sat_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_red
    logic hi;
    logic lo;
    assign hi = acc_d[gi] > SAT_MAX;
    assign lo = acc_d[gi] < SAT_MIN;
    assign clip[gi] = hi | lo;
    assign res_d[gi] = hi ? SAT_MAX[OUT_W-1:0] : (lo ? SAT_MIN[OUT_W-1:0] : acc_d[gi][OUT_W-1:0]);
  end
  assign sat_d    = |clip;
  assign sat_flag = sat_q;
`else
  for (genvar gi = 0; gi < 4; gi++) begin : g_red
    assign res_d[gi] = acc_d[gi][OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      acc_q       <= '{default: '0};
      res_q       <= '{default: '0};
`ifdef QMUL_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a_cap;
            b_q        <= b_cap;
            acc_q      <= '{default: '0};
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          k_q   <= k_q + K_STEP;
          if (k_q == K_LAST) begin
            res_q       <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
`ifdef QMUL_SAT_EN
            sat_q       <= sat_d;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
`ifdef QMUL_SAT_EN
            sat_q       <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q0 = res_q[0];
  assign q1 = res_q[1];
  assign q2 = res_q[2];
  assign q3 = res_q[3];

endmodule

// File: tb/tb_quaternion_mult_seq.sv
// Bench for quaternion_mult_seq: four instances (MULTS=1/2/4, OUT_W=32) against a plain Hamilton-product model.
// Honours the QMUL_SAT_EN build macro for reduction and sat_flag checks.
module tb_quaternion_mult_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               conj_b;
  logic signed [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [3:0]         iv, ir, ov, ordy;
  logic [3:0][33:0]   qu0, qu1, qu2;
  logic [3:0][31:0]   qu3;
`ifdef QMUL_SAT_EN
  logic [3:0]         sf;
`endif

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  quaternion_mult_seq #(.W(16), .OUT_W(34), .MULTS(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .conj_b(conj_b),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .q0(qu0[0]), .q1(qu0[1]), .q2(qu0[2]), .q3(qu0[3])
`ifdef QMUL_SAT_EN
    , .sat_flag(sf[0])
`endif
  );

  quaternion_mult_seq #(.W(16), .OUT_W(34), .MULTS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .conj_b(conj_b),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .q0(qu1[0]), .q1(qu1[1]), .q2(qu1[2]), .q3(qu1[3])
`ifdef QMUL_SAT_EN
    , .sat_flag(sf[1])
`endif
  );

  quaternion_mult_seq #(.W(16), .OUT_W(34), .MULTS(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .conj_b(conj_b),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .q0(qu2[0]), .q1(qu2[1]), .q2(qu2[2]), .q3(qu2[3])
`ifdef QMUL_SAT_EN
    , .sat_flag(sf[2])
`endif
  );

  quaternion_mult_seq #(.W(16), .OUT_W(32), .MULTS(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .conj_b(conj_b),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(ov[3]), .out_ready(ordy[3]),
    .q0(qu3[0]), .q1(qu3[1]), .q2(qu3[2]), .q3(qu3[3])
`ifdef QMUL_SAT_EN
    , .sat_flag(sf[3])
`endif
  );

  typedef struct {
    int               unit;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    bit               cj;
    logic [3:0][63:0] e;
    bit               esat;
  } vec_t;

  function automatic int mults_of(input int u);
    return (u == 1) ? 2 : ((u == 2) ? 4 : 1);
  endfunction

  function automatic int outw_of(input int u);
    return (u == 3) ? 32 : 34;
  endfunction

  function automatic longint getq(input int u, input int i);
    case (u)
      0:       return longint'($signed(qu0[i]));
      1:       return longint'($signed(qu1[i]));
      2:       return longint'($signed(qu2[i]));
      default: return longint'($signed(qu3[i]));
    endcase
  endfunction

  function automatic logic [3:0][15:0] p16(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][15:0] r;
    r[0] = x0[15:0];
    r[1] = x1[15:0];
    r[2] = x2[15:0];
    r[3] = x3[15:0];
    return r;
  endfunction

  function automatic logic [3:0][63:0] p64(input longint x0, input longint x1, input longint x2, input longint x3);
    logic [3:0][63:0] r;
    r[0] = x0;
    r[1] = x1;
    r[2] = x2;
    r[3] = x3;
    return r;
  endfunction

  // Reference: textbook Hamilton product, then reduction of each component to ow bits.
  function automatic logic [3:0][63:0] model(input logic [3:0][15:0] av, input logic [3:0][15:0] bv,
                                             input bit cj, input int ow, output bit clipped);
    longint a[4];
    longint b[4];
    longint r[4];
    logic [3:0][63:0] res;
    clipped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[i] = longint'($signed(av[i]));
      b[i] = longint'($signed(bv[i]));
      if (cj && i > 0) b[i] = -b[i];
    end
    r[0] = a[0]*b[0] - a[1]*b[1] - a[2]*b[2] - a[3]*b[3];
    r[1] = a[0]*b[1] + a[1]*b[0] + a[2]*b[3] - a[3]*b[2];
    r[2] = a[0]*b[2] - a[1]*b[3] + a[2]*b[0] + a[3]*b[1];
    r[3] = a[0]*b[3] + a[1]*b[2] - a[2]*b[1] + a[3]*b[0];
    for (int i = 0; i < 4; i++) begin
`ifdef QMUL_SAT_EN
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (ow-1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow-1));
      if (r[i] > hi) begin r[i] = hi; clipped = 1'b1; end
      if (r[i] < lo) begin r[i] = lo; clipped = 1'b1; end
`else
      r[i] = (r[i] <<< (64-ow)) >>> (64-ow);
`endif
      res[i] = r[i];
    end
    return res;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic run_txn(input int u, input logic [3:0][15:0] av, input logic [3:0][15:0] bv,
                         input bit cj, input logic [3:0][63:0] ex, input bit ex_sat, input string tag);
    int lat;
    bit ok;
    a0 = av[0]; a1 = av[1]; a2 = av[2]; a3 = av[3];
    b0 = bv[0]; b1 = bv[1]; b2 = bv[2]; b3 = bv[3];
    conj_b = cj;
    iv[u] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ir[u]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      iv[u] = 1'b0;
      chk({tag, "_accept"}, 0, 1);
      return;
    end
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    lat = 0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ov[u]) begin ok = 1'b1; break; end
    end
    chk({tag, "_latency"}, lat, 16 / mults_of(u));
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_q%0d", tag, i), getq(u, i), $signed(ex[i]));
      end
`ifdef QMUL_SAT_EN
      chk({tag, "_sat_flag"}, longint'(sf[u]), longint'(ex_sat));
`endif
    end
    $display("txn %s unit=%0d conj=%0d lat=%0d q=(%0d,%0d,%0d,%0d)", tag, u, cj, lat,
             getq(u, 0), getq(u, 1), getq(u, 2), getq(u, 3));
  endtask

  function automatic logic [15:0] rnd16();
    int s;
    logic [31:0] r;
    s = $urandom_range(0, 7);
    r = $urandom();
    if (s == 0) return 16'h8000;
    if (s == 1) return 16'h7fff;
    return r[15:0];
  endfunction

  vec_t tbl [7];

  initial begin
    bit clip;
    bit stable;
    logic [3:0][63:0] ex;
    logic [3:0][15:0] ra;
    logic [3:0][15:0] rb;
    bit rc;
    int u;

    rst = 1'b0; iv = '0; ordy = '1; conj_b = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;

    tbl[0] = '{0, p16(1, 2, 3, 4), p16(5, 6, 7, 8), 1'b0, p64(-60, 12, 30, 24), 1'b0};
    tbl[1] = '{0, p16(-1, 0, -3, 2), p16(2, -1, 1, 0), 1'b0, p64(1, -1, -9, 1), 1'b0};
    tbl[2] = '{0, p16(0, 0, 0, 0), p16(0, 0, 0, 0), 1'b0, p64(0, 0, 0, 0), 1'b0};
    tbl[3] = '{0, p16(1, 2, 3, 4), p16(5, 6, 7, 8), 1'b1, p64(70, 8, 0, 16), 1'b0};
    tbl[4] = '{1, p16(1, 2, 3, 4), p16(5, 6, 7, 8), 1'b1, p64(70, 8, 0, 16), 1'b0};
    tbl[5] = '{2, p16(1, 2, 3, 4), p16(5, 6, 7, 8), 1'b1, p64(70, 8, 0, 16), 1'b0};
`ifdef QMUL_SAT_EN
    tbl[6] = '{3, p16(32767, 32767, 32767, 32767), p16(32767, -32767, -32767, -32767), 1'b0,
               p64(2147483647, 0, 0, 0), 1'b1};
`else
    tbl[6] = '{3, p16(32767, 32767, 32767, 32767), p16(32767, -32767, -32767, -32767), 1'b0,
               p64(-262140, 0, 0, 0), 1'b0};
`endif

    // Reset state and release behaviour.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(ir[0]), 0);
    chk("rst_out_valid", longint'(ov[0]), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_q%0d", i), getq(0, i), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_in_ready_low", longint'(ir[0]), 0);
    @(posedge clk);
    #1;
    chk("release_in_ready_high", longint'(ir[0]), 1);

    for (int n = 0; n < 7; n++) begin
      run_txn(tbl[n].unit, tbl[n].a, tbl[n].b, tbl[n].cj, tbl[n].e, tbl[n].esat, $sformatf("vec%0d", n));
    end

    for (int n = 0; n < 40; n++) begin
      u = n % 4;
      for (int i = 0; i < 4; i++) begin
        ra[i] = rnd16();
        rb[i] = rnd16();
      end
      rc = 1'($urandom_range(0, 1));
      ex = model(ra, rb, rc, outw_of(u), clip);
      run_txn(u, ra, rb, rc, ex, clip, $sformatf("rnd%0d", n));
    end

    // Backpressure: result must sit still while out_ready is low, then a one-cycle pulse retires it.
    ordy[0] = 1'b0;
    run_txn(0, tbl[0].a, tbl[0].b, 1'b0, tbl[0].e, 1'b0, "bp");
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ov[0] || ir[0]) stable = 1'b0;
      for (int i = 0; i < 4; i++) if (getq(0, i) != $signed(tbl[0].e[i])) stable = 1'b0;
    end
    chk("bp_hold_stable", longint'(stable), 1);
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_pulse_out_valid", longint'(ov[0]), 0);
    chk("bp_pulse_in_ready", longint'(ir[0]), 1);
    chk("bp_keep_q0", getq(0, 0), -60);
    stable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ov[0]) stable = 1'b0;
    end
    chk("bp_single_handshake", longint'(stable), 1);
    ordy[0] = 1'b1;

    // Reset asserted in the middle of the 8th busy cycle.
    a0 = 16'sd1; a1 = 16'sd2; a2 = 16'sd3; a3 = 16'sd4;
    b0 = 16'sd5; b1 = 16'sd6; b2 = 16'sd7; b3 = 16'sd8;
    conj_b = 1'b0;
    iv[0] = 1'b1;
    stable = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ir[0]) begin stable = 1'b1; break; end
    end
    chk("midrst_accept", longint'(stable), 1);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(ov[0]), 0);
    chk("midrst_in_ready", longint'(ir[0]), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_q%0d", i), getq(0, i), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stable = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (ov[0]) stable = 1'b0;
    end
    chk("midrst_no_stray_valid", longint'(stable), 1);
    run_txn(0, tbl[1].a, tbl[1].b, 1'b0, tbl[1].e, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
